// File: rtl/noc_params.sv
// Shared router parameters and types: port count, port index width,
// port names and flit labels.
package noc_params;

  localparam int PORT_NUM  = 5;
  localparam int PORT_SIZE = $clog2(PORT_NUM);

  typedef enum logic [PORT_SIZE-1:0] {
    LOCAL,
    NORTH,
    SOUTH,
    WEST,
    EAST
  } port_t;

  typedef enum logic [1:0] {
    HEAD,
    BODY,
    TAIL,
    HEADTAIL
  } flit_label_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// scanning upward from ptr and wrapping N-1 -> 0. The caller owns ptr.
module round_robin_arbiter #(
  parameter int  N     = 5,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  // Scan from ptr upward with wrap; the first set request wins.
  always_comb begin
    int          idx_int;
    logic [PTR_W-1:0] idx;
    logic        found;
    gnt     = '0;
    found   = 1'b0;
    idx_int = 0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx_int = int'(ptr) + k;
      if (idx_int >= N) begin
        idx_int = idx_int - N;
      end
      idx = PTR_W'(idx_int);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-router switch allocator. One round-robin arbiter per output port,
// wormhole lock held from HEAD to TAIL, packet-granular fairness (pointer
// advances only on HEAD/HEADTAIL). Grants are combinational; crossbar
// selects are registered for the following traversal cycle.
// Optional feature: define SA_PERF_CNT_EN to add per-output saturating
// 16-bit grant counters on grant_cnt_o.
module switch_allocator #(
  parameter int  PORT_NUM  = noc_params::PORT_NUM,
  localparam int PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PORT_NUM-1:0]                request_i,
  input  logic [PORT_NUM-1:0][PORT_SIZE-1:0] out_port_i,
  input  logic [PORT_NUM-1:0][1:0]           flit_label_i,
  input  logic [PORT_NUM-1:0]                on_off_i,
  output logic [PORT_NUM-1:0]                grant_o,
  output logic [PORT_NUM-1:0][PORT_SIZE-1:0] xb_sel_o,
  output logic [PORT_NUM-1:0]                xb_valid_o
`ifdef SA_PERF_CNT_EN
  ,
  output logic [PORT_NUM-1:0][15:0]          grant_cnt_o
`endif
);
  import noc_params::*;

  // arb_gnt[p][i]: output p's arbiter grants input i this cycle
  logic [PORT_NUM-1:0][PORT_NUM-1:0] arb_gnt;
  logic [PORT_NUM-1:0]               grant_any;

  genvar gi, gj;
  generate
    for (gi = 0; gi < PORT_NUM; gi++) begin : gen_out
      logic [PORT_NUM-1:0]  cand;
      logic [PORT_NUM-1:0]  elig;
      logic [PORT_NUM-1:0]  owner_mask;
      logic                 locked_reg;
      logic [PORT_SIZE-1:0] owner_reg;
      logic [PORT_SIZE-1:0] ptr_reg;
      logic                 xb_valid_reg;
      logic [PORT_SIZE-1:0] xb_sel_reg;
      logic [PORT_SIZE-1:0] win_idx;
      logic [PORT_SIZE-1:0] ptr_next;
      logic                 win_any;
      flit_label_t          win_label;

      // Inputs whose routed output is this port
      for (gj = 0; gj < PORT_NUM; gj++) begin : gen_cand
        assign cand[gj] = request_i[gj] && (out_port_i[gj] == PORT_SIZE'(gi));
      end

      // While locked only the packet owner may compete; back-pressure blocks all
      assign owner_mask = PORT_NUM'(1) << owner_reg;
      assign elig = !on_off_i[gi] ? '0 :
                    (locked_reg ? (cand & owner_mask) : cand);

      round_robin_arbiter #(.N(PORT_NUM)) u_arb (
        .req (elig),
        .ptr (ptr_reg),
        .gnt (arb_gnt[gi])
      );

      // One-hot grant to winner index
      always_comb begin
        win_idx = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
          if (arb_gnt[gi][i]) begin
            win_idx = PORT_SIZE'(i);
          end
        end
      end

      assign win_any   = |arb_gnt[gi];
      assign win_label = flit_label_t'(flit_label_i[win_idx]);
      assign ptr_next  = (win_idx == PORT_SIZE'(PORT_NUM - 1)) ? '0
                                                                : win_idx + PORT_SIZE'(1);

      // Lock/owner/pointer update on a grant, plus crossbar select pipeline
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          locked_reg   <= 1'b0;
          owner_reg    <= '0;
          ptr_reg      <= '0;
          xb_valid_reg <= 1'b0;
          xb_sel_reg   <= '0;
        end else begin
          xb_valid_reg <= win_any;
          xb_sel_reg   <= win_idx;
          if (win_any) begin
            case (win_label)
              HEAD: begin
                locked_reg <= 1'b1;
                owner_reg  <= win_idx;
                ptr_reg    <= ptr_next;
              end
              HEADTAIL: ptr_reg <= ptr_next;
              TAIL:     locked_reg <= 1'b0;
              default:  ;
            endcase
          end
        end
      end

      assign xb_valid_o[gi] = xb_valid_reg;
      assign xb_sel_o[gi]   = xb_sel_reg;

`ifdef SA_PERF_CNT_EN
      logic [15:0] cnt_reg;

      // Saturating count of grants issued on this output
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (win_any && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end

      assign grant_cnt_o[gi] = cnt_reg;
`endif
    end
  endgenerate

  // Each input targets one output, so OR-ing across outputs gives its grant
  always_comb begin
    grant_any = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      grant_any = grant_any | arb_gnt[p];
    end
  end

  assign grant_o = grant_any & {PORT_NUM{rst_n}};

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-router switch allocator that sits between the input ports (which own the RC unit result and flit buffers) and the crossbar. Each cycle it arbitrates, per output port, among input ports requesting that output. It uses round-robin fairness at packet granularity and wormhole locking from HEAD to TAIL. Grants return combinationally to the inputs; crossbar selects are registered for the following switch-traversal cycle.

## Interface
- PORT_NUM, default PORT_NUM from noc_params (5), number of router ports, indexed by port_t (LOCAL, NORTH, SOUTH, WEST, EAST).
- clk  input  1  router clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- request_i  input  PORT_NUM  input i holds a flit ready to traverse.
- out_port_i  input  PORT_NUM x port_t  output port computed by input i's RC unit; valid when request_i[i].
- flit_label_i  input  PORT_NUM x flit_label_t  label of input i's front flit (HEAD, BODY, TAIL, HEADTAIL).
- on_off_i  input  PORT_NUM  output p's downstream can accept a flit this cycle.
- grant_o  output  PORT_NUM  input i wins this cycle; input pops its flit at next edge.
- xb_sel_o  output  PORT_NUM x PORT_SIZE  per output p, index of input granted in previous cycle.
- xb_valid_o  output  PORT_NUM  xb_sel_o[p] carries a flit this cycle.
- grant_cnt_o  output  PORT_NUM x 16  per-output saturating grant count (only with SA_PERF_CNT_EN).

## Operation
- State per output p: ptr[p] (PORT_SIZE bits, priority start index), locked[p], owner[p].
- Candidate set for p: inputs i with request_i[i] and out_port_i[i]==p.
- If locked[p]: only owner[p] is eligible. Other requesters to p get no grant.
- If not locked[p]: round-robin pick starting at ptr[p], wrapping PORT_NUM-1 -> 0.
- No grant for p when on_off_i[p]==0. Lock, owner and ptr are unchanged.
- Each input requests one output, so grant_o[i] = OR over p of arbiter grant for i. At most one grant per input and per output.
- On grant of input w to output p:
  - HEAD: locked[p]<=1, owner[p]<=w, ptr[p]<=(w+1) mod PORT_NUM.
  - HEADTAIL: no lock, ptr[p]<=(w+1) mod PORT_NUM.
  - BODY: no state change.
  - TAIL: locked[p]<=0. ptr unchanged, already advanced at HEAD.
- BODY/TAIL from a non-owner while p is unlocked is a protocol error. It is arbitrated normally and does not alter lock. Verification flags it with an assertion.
- Owner requesting a different output while its lock is held is not expected. The lock persists until that owner's TAIL reaches p.

## Timing
- grant_o is combinational from the request, label and on_off inputs plus current state; zero-cycle request-to-grant.
- xb_sel_o/xb_valid_o are registered: grant in cycle N drives crossbar in cycle N+1. Latency 1.
- Back-to-back grants to the same output in consecutive cycles are allowed (full throughput).
- Reset (rst_n low, any cycle, including mid-packet): grant_o forced 0, locked=0, owner=0, ptr=0 (LOCAL first), xb_valid_o=0, xb_sel_o=0, grant_cnt_o=0. Mid-packet locks are discarded; upstream must also reset.
- The first edge after deassertion may already register grants.

## Configuration
- SA_PERF_CNT_EN defined: grant_cnt_o exists. Each counter increments on every grant to p and saturates at 16'hFFFF. Reset value is 0.
- SA_PERF_CNT_EN undefined: no grant_cnt_o port and no counter flops. All other behaviour is identical.

## Structure
- noc_params holds PORT_NUM, PORT_SIZE = $clog2(PORT_NUM), port_t and flit_label_t. No new typedefs are local to this block.
- Sub-module round_robin_arbiter (parameter N): inputs req[N] and ptr; outputs one-hot gnt. It is purely combinational. There is one instance per output port, and the allocator owns ptr/lock state.

## Test plan
- Reset: hold rst_n=0 with all request_i=1 -> grant_o=0, xb_valid_o=0. Release; all 5 inputs send HEADTAIL to EAST -> grants LOCAL, NORTH, SOUTH, WEST, EAST on consecutive cycles, then LOCAL again.
- Lock: NORTH sends HEAD, BODY, BODY, TAIL to WEST while SOUTH sends HEADTAIL to WEST continuously -> NORTH granted 4 cycles uninterrupted, SOUTH granted cycle 5.
- Back-pressure: NORTH holds a HEAD-locked packet to LOCAL and on_off_i[LOCAL]=0 for 3 cycles -> no grants and lock held. On re-enable, NORTH's BODY is granted first even with EAST requesting LOCAL.
- Parallelism: LOCAL->EAST and WEST->NORTH HEADTAIL in the same cycle -> both granted; next cycle xb_sel_o[EAST]=LOCAL, xb_sel_o[NORTH]=WEST, both valid.
- Reset mid-packet: rst_n pulses low after HEAD and 1 BODY from SOUTH to EAST -> lock cleared. After release, NORTH HEADTAIL to EAST is granted immediately.
- SA_PERF_CNT_EN: 70000 grants to EAST -> grant_cnt_o[EAST]=16'hFFFF, other counters match their grant counts.
